conv2_mac_sequencer: RTL and testbench
======================================

CONV2_MAC_SEQUENCER -- requirements
Module: conv2_mac_sequencer

Interface
REQ-001 Parameter: CNT_W, default 4, width of group count; legal num_groups 1..2^CNT_W-1.
REQ-002 Parameter: ACC_W, default 24, width of signed accumulator and result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  job request; sampled only in IDLE.
REQ-006 num_groups  input  CNT_W  6-product groups per result; sampled with start.
REQ-007 op_valid  input  1  operand buffer presents one 12-operand group to the multiply stage.
REQ-008 op_ready  output  1  sequencer accepts current operand group.
REQ-009 mul_enable  output  1  drives multiply-stage enable.
REQ-010 mul_done  input  1  multiply-stage done flag; products valid when high.
REQ-011 prod1..prod6  input  16 each, signed  multiply-stage products.
REQ-012 result_valid  output  1  accumulated result available.
REQ-013 result_data  output  ACC_W, signed  accumulated result.
REQ-014 result_ready  input  1  consumer accepts result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DRAIN, OUT.
REQ-017 IDLE: start=1 and num_groups!=0 -> FETCH; latch remaining=num_groups; clear acc to 0.
REQ-018 IDLE: start=1 with num_groups=0 -> ignored; remain IDLE, no result.
REQ-019 start SHALL be ignored in FETCH, DRAIN, OUT.
REQ-020 op_ready = 1 only in FETCH; combinational from state only, never from op_valid.
REQ-021 mul_enable = op_valid & op_ready, combinational; operands pass from buffer to multiply stage directly.
REQ-022 Handshake (op_valid & op_ready at an edge): remaining decrements by 1; remaining=1 at handshake -> DRAIN.
REQ-023 FETCH with op_valid=0: no decrement, no enable, stay FETCH indefinitely.
REQ-024 Accumulate: at any edge in FETCH or DRAIN with mul_done=1, acc += sign-extended (prod1+...+prod6).
REQ-025 mul_done SHALL be ignored in IDLE and OUT.
REQ-026 Sum and accumulation SHALL be two's-complement, wrapping modulo 2^ACC_W; no saturation.
REQ-027 DRAIN lasts exactly one cycle: at next edge, final products accumulated, result_data <= final acc, -> OUT.
REQ-028 OUT: result_valid=1, result_data held stable until result_ready=1 at an edge -> IDLE.
REQ-029 result_valid and result_ready high in same edge SHALL complete transfer; next job start accepted no earlier than the following edge.
REQ-030 Latency: start at edge 0, op_valid continuously 1 -> handshakes at edges 1..N, result_valid high after edge N+1.
REQ-031 Throughput: one group per cycle in FETCH; no bubbles inserted by sequencer.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, acc=0, remaining=0, result_data=0, result_valid=0; op_ready, mul_enable, busy therefore 0.
REQ-033 Reset mid-job (any state) SHALL discard partial accumulation; no result emitted for that job.
REQ-034 After reset deassertion, first start SHALL behave as in REQ-017.

Verification
REQ-035 N=1, all prods=6 on the cycle after enable -> result_data=36, result_valid after edge 2, busy 1 from edge 0 to transfer.
REQ-036 N=3, each prod=-16256 (-128*127) -> result_data=-292608; check sign extension at ACC_W=24.
REQ-037 N=4, op_valid low for 2 cycles between groups 2 and 3 -> mul_enable exactly 4 cycles high, result equals sum of 24 products, no double count.
REQ-038 Result held with result_ready=0 for 5 cycles; start pulsed meanwhile -> result_data stable, start ignored, one result only.
REQ-039 start with num_groups=0 -> busy stays 0, op_ready stays 0, no result_valid.
REQ-040 reset asserted in FETCH after 2 of 5 groups, then new job N=1 prods=1 -> result_data=6, no residue from aborted job.

Source files
------------

// File: rtl/conv2_mac_sequencer.sv
// Sequencer for a 6-lane multiply stage. It streams operand groups to the multiplier,
// accumulates the lagging products, and presents one signed result per job.
module conv2_mac_sequencer #(
    parameter int CNT_W = 4,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_groups,
    input  logic                    op_valid,
    output logic                    op_ready,
    output logic                    mul_enable,
    input  logic                    mul_done,
    input  logic signed [15:0]      prod1,
    input  logic signed [15:0]      prod2,
    input  logic signed [15:0]      prod3,
    input  logic signed [15:0]      prod4,
    input  logic signed [15:0]      prod5,
    input  logic signed [15:0]      prod6,
    output logic                    result_valid,
    output logic signed [ACC_W-1:0] result_data,
    input  logic                    result_ready,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        remaining_q, remaining_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] result_q, result_d;
    logic signed [ACC_W-1:0] prod_sum;
    logic                    job_start;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [15:0] p);
        sext = {{(ACC_W-16){p[15]}}, p};
    endfunction

    // Lanes are widened before summing so the total wraps only at ACC_W bits.
    assign prod_sum = sext(prod1) + sext(prod2) + sext(prod3)
                    + sext(prod4) + sext(prod5) + sext(prod6);

    assign job_start  = start && (num_groups != '0);
    assign mul_enable = op_valid & op_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (job_start) state_d = FETCH;
            FETCH:   if (mul_enable && (remaining_q == CNT_W'(1))) state_d = DRAIN;
            DRAIN:   state_d = OUT;
            OUT:     if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Products trail the enable by one cycle, so DRAIN catches the last group's sum.
    always_comb begin
        remaining_d = remaining_q;
        acc_d       = acc_q;
        result_d    = result_q;
        case (state_q)
            IDLE: begin
                if (job_start) begin
                    remaining_d = num_groups;
                    acc_d       = '0;
                end
            end
            FETCH: begin
                if (mul_enable) remaining_d = remaining_q - CNT_W'(1);
                if (mul_done)   acc_d = acc_q + prod_sum;
            end
            DRAIN: begin
                if (mul_done) acc_d = acc_q + prod_sum;
                result_d = acc_d;
            end
            default: ;
        endcase
    end

    always_comb begin
        op_ready     = (state_q == FETCH);
        result_valid = (state_q == OUT);
        busy         = (state_q != IDLE);
    end

    assign result_data = result_q;

endmodule

// File: tb/tb_conv2_mac_sequencer.sv
// Directed bench for conv2_mac_sequencer with a one-cycle-latency multiply-stage model.
module tb_conv2_mac_sequencer;

   localparam int CNT_W = 4;
   localparam int ACC_W = 24;
   localparam logic signed [15:0] JUNK = 16'sh3a3a;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    start;
   logic [CNT_W-1:0]        num_groups;
   logic                    op_valid;
   logic                    op_ready;
   logic                    mul_enable;
   logic                    mul_done;
   logic signed [15:0]      prod_val;
   logic                    result_valid;
   logic signed [ACC_W-1:0] result_data;
   logic                    result_ready;
   logic                    busy;

   int checks   = 0;
   int failures = 0;
   int grp_idx  = 0;
   int enable_count = 0;
   int base     = 0;
   int lat;
   int en0;
   logic signed [15:0] grp_val [0:63];

   conv2_mac_sequencer #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .reset(reset), .start(start), .num_groups(num_groups),
      .op_valid(op_valid), .op_ready(op_ready), .mul_enable(mul_enable),
      .mul_done(mul_done),
      .prod1(prod_val), .prod2(prod_val), .prod3(prod_val),
      .prod4(prod_val), .prod5(prod_val), .prod6(prod_val),
      .result_valid(result_valid), .result_data(result_data),
      .result_ready(result_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   // Multiply stage: products for an enabled group appear one cycle later; junk otherwise.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mul_done <= 1'b0;
         prod_val <= JUNK;
      end else begin
         mul_done <= mul_enable;
         prod_val <= mul_enable ? grp_val[grp_idx] : JUNK;
         if (mul_enable) begin
            grp_idx      <= grp_idx + 1;
            enable_count <= enable_count + 1;
         end
      end
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task check_output(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task begin_job();
      base = grp_idx;
   endtask

   task set_group(input int k, input logic signed [15:0] v);
      grp_val[base + k] = v;
   endtask

   task wait_result(input int max_cycles, output int cycles);
      cycles = 0;
      while (!result_valid && cycles < max_cycles) begin
         @(negedge clk);
         cycles++;
      end
      if (!result_valid) check_output("result_timeout", 0, 1);
   endtask

   task transfer_result();
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) grp_val[i] = JUNK;
      reset = 1'b1; start = 1'b0; num_groups = '0; op_valid = 1'b0; result_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_output("rst_busy", busy, 0);
      check_output("rst_op_ready", op_ready, 0);
      check_output("rst_result_valid", result_valid, 0);
      check_output("rst_result_data", result_data, 0);
      reset = 1'b0;
      @(negedge clk);

      // N=1, six products of 6
      begin_job(); set_group(0, 16'sd6);
      start = 1'b1; num_groups = 4'd1; op_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_output("t1_busy_e0", busy, 1);
      check_output("t1_op_ready_e0", op_ready, 1);
      check_output("t1_mul_enable_e0", mul_enable, 1);
      @(negedge clk);
      op_valid = 1'b0;
      check_output("t1_op_ready_drain", op_ready, 0);
      check_output("t1_result_valid_e1", result_valid, 0);
      check_output("t1_busy_e1", busy, 1);
      @(negedge clk);
      check_output("t1_result_valid_e2", result_valid, 1);
      check_output("t1_result_data", result_data, 36);
      check_output("t1_busy_e2", busy, 1);
      transfer_result();
      check_output("t1_busy_after", busy, 0);
      check_output("t1_valid_after", result_valid, 0);

      // N=3, negative products, latency N+1
      begin_job();
      for (int k = 0; k < 3; k++) set_group(k, -16'sd16256);
      start = 1'b1; num_groups = 4'd3; op_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_result(20, lat);
      op_valid = 1'b0;
      check_output("t2_latency", lat, 4);
      check_output("t2_result_data", result_data, -292608);
      transfer_result();

      // N=4 with a two-cycle op_valid gap between groups 2 and 3
      begin_job(); en0 = enable_count;
      set_group(0, 16'sd100); set_group(1, -16'sd200); set_group(2, 16'sd300); set_group(3, 16'sd1000);
      start = 1'b1; num_groups = 4'd4; op_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      op_valid = 1'b0;
      @(negedge clk);
      check_output("t3_gap_op_ready", op_ready, 1);
      check_output("t3_gap_mul_enable", mul_enable, 0);
      @(negedge clk);
      check_output("t3_gap_busy", busy, 1);
      op_valid = 1'b1;
      repeat (2) @(negedge clk);
      op_valid = 1'b0;
      wait_result(20, lat);
      check_output("t3_result_data", result_data, 7200);
      check_output("t3_enable_cycles", enable_count - en0, 4);

      // Hold the result for 5 cycles while pulsing start
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         num_groups = 4'd2;
         @(negedge clk);
         start = 1'b0;
         check_output("t4_hold_valid", result_valid, 1);
         check_output("t4_hold_data", result_data, 7200);
      end
      result_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      result_ready = 1'b0; start = 1'b0;
      check_output("t4_start_at_transfer", busy, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("t4_single_result", result_valid, 0);
      end

      // num_groups = 0 is ignored
      start = 1'b1; num_groups = 4'd0; op_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_output("t5_busy", busy, 0);
         check_output("t5_op_ready", op_ready, 0);
         check_output("t5_mul_enable", mul_enable, 0);
         check_output("t5_result_valid", result_valid, 0);
         @(negedge clk);
      end
      op_valid = 1'b0;

      // Reset after 2 of 5 groups, then a fresh N=1 job
      begin_job();
      for (int k = 0; k < 5; k++) set_group(k, 16'sd50);
      start = 1'b1; num_groups = 4'd5; op_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_output("t6_rst_busy", busy, 0);
      check_output("t6_rst_op_ready", op_ready, 0);
      check_output("t6_rst_mul_enable", mul_enable, 0);
      check_output("t6_rst_result_valid", result_valid, 0);
      check_output("t6_rst_result_data", result_data, 0);
      op_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      begin_job(); set_group(0, 16'sd1);
      start = 1'b1; num_groups = 4'd1; op_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      op_valid = 1'b0;
      wait_result(10, lat);
      check_output("t6_result_data", result_data, 6);
      transfer_result();
      check_output("t6_busy_after", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
